// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle ops and an iterative shift-add multiply.
// Results are held in DONE until the consumer takes them.
module seq_alu #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       aluk,
   input  logic [WIDTH-1:0] one,
   input  logic [WIDTH-1:0] two,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] q,
   output logic [2:0]       nzp,
   output logic [1:0]       cv,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int SW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           state_q, state_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d, acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, alu_w, acc_n;
   logic [1:0]       cv_q, cv_d;
   logic             err_q, err_d;
   logic [WIDTH:0]   add_w, sub_w;
   logic [SW-1:0]    sh_w;
   logic             is_mul_w, legal_w, add_ov_w, sub_ov_w;
   assign sh_w     = two[SW-1:0];
   assign add_w    = {1'b0, one} + {1'b0, two};
   // Subtract as A + ~B + 1 so bit WIDTH reads as "no borrow"
   assign sub_w    = {1'b0, one} + {1'b0, ~two} + 1'b1;
   assign add_ov_w = (one[WIDTH-1] == two[WIDTH-1]) && (add_w[WIDTH-1] != one[WIDTH-1]);
   assign sub_ov_w = (one[WIDTH-1] != two[WIDTH-1]) && (sub_w[WIDTH-1] != one[WIDTH-1]);
   assign is_mul_w = MUL_EN && (aluk == 4'd10);
   assign legal_w  = (aluk < 4'd10) || is_mul_w;
   assign acc_n    = acc_q + (mplier_q[0] ? mcand_q : '0);
   always_comb begin
      case (aluk)
         4'd0:    alu_w = add_w[WIDTH-1:0];
         4'd1:    alu_w = one & two;
         4'd2:    alu_w = ~one;
         4'd3:    alu_w = one;
         4'd4:    alu_w = sub_w[WIDTH-1:0];
         4'd5:    alu_w = one | two;
         4'd6:    alu_w = one ^ two;
         4'd7:    alu_w = one << sh_w;
         4'd8:    alu_w = one >> sh_w;
         4'd9:    alu_w = WIDTH'($signed(one) >>> sh_w);
         default: alu_w = '0;
      endcase
   end
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      q_d      = q_q;
      cv_d     = cv_q;
      err_d    = err_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      case (state_q)
         IDLE: if (in_valid) begin
            err_d = !legal_w;
            cv_d  = (aluk == 4'd0) ? {add_w[WIDTH], add_ov_w} :
                    (aluk == 4'd4) ? {sub_w[WIDTH], sub_ov_w} : 2'b00;
            if (is_mul_w) begin
               state_d  = BUSY;
               cnt_d    = SW'(WIDTH - 1);
               acc_d    = '0;
               mcand_d  = one;
               mplier_d = two;
            end else begin
               state_d = DONE;
               q_d     = legal_w ? alu_w : '0;
            end
         end
         BUSY: begin
            acc_d    = acc_n;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
               state_d = DONE;
               q_d     = acc_n;
            end else cnt_d = cnt_q - 1'b1;
         end
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         q_q      <= '0;
         cv_q     <= '0;
         err_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         cv_q     <= cv_d;
         err_q    <= err_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign q         = q_q;
   assign cv        = cv_q;
   assign err       = err_q;
   assign nzp       = out_valid ? {q_q[WIDTH-1], q_q == '0, !q_q[WIDTH-1] && (q_q != '0)} : 3'b000;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu (WIDTH=16) plus a MUL_EN=0 instance for the illegal-MUL case.
module tb_seq_alu;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  aluk = '0;
   logic [15:0] one = '0, two = '0;
   logic        in_valid = 1'b0, in_valid0 = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, err, in_ready0, out_valid0, err0;
   logic [15:0] q, q0;
   logic [2:0]  nzp, nzp0;
   logic [1:0]  cv, cv0;
   int          n_chk = 0, n_err = 0, lat;
   logic [15:0] held;
   seq_alu #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .aluk(aluk), .one(one), .two(two),
      .in_valid(in_valid), .in_ready(in_ready), .q(q), .nzp(nzp), .cv(cv),
      .err(err), .out_valid(out_valid), .out_ready(out_ready));
   seq_alu #(.WIDTH(16), .MUL_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .aluk(aluk), .one(one), .two(two),
      .in_valid(in_valid0), .in_ready(in_ready0), .q(q0), .nzp(nzp0), .cv(cv0),
      .err(err0), .out_valid(out_valid0), .out_ready(out_ready));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int l);
      aluk = op; one = a; two = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; one = '1; two = '1;
      l = 1;
      while (!out_valid && l < 100) begin
         @(posedge clk); #1;
         l++;
      end
   endtask
   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask
   task automatic op_chk(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [2:0] enzp, input logic [1:0] ecv, input logic eerr);
      int l;
      run_op(op, a, b, l);
      chk({tag, " lat"}, l, 1);
      chk({tag, " q"}, q, eq);
      chk({tag, " nzp"}, nzp, enzp);
      chk({tag, " cv"}, cv, ecv);
      chk({tag, " err"}, err, eerr);
      ack();
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst q", q, 0);
      chk("rst nzp", nzp, 0);
      chk("rst cv", cv, 0);
      chk("rst err", err, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst in_ready", in_ready, 1);
      rst_n = 1'b1;
      run_op(4'd0, 16'h7FFF, 16'h0001, lat);
      chk("add ovf lat", lat, 1);
      chk("add ovf q", q, 16'h8000);
      chk("add ovf nzp", nzp, 3'b100);
      chk("add ovf cv", cv, 2'b01);
      chk("add ovf err", err, 0);
      chk("add ovf in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("add hold valid", out_valid, 1);
      chk("add hold q", q, 16'h8000);
      ack();
      chk("ack in_ready", in_ready, 1);
      chk("ack out_valid", out_valid, 0);
      op_chk("sub eq", 4'd4, 16'h0005, 16'h0005, 16'h0000, 3'b010, 2'b10, 1'b0);
      op_chk("not", 4'd2, 16'h00FF, 16'h1234, 16'hFF00, 3'b100, 2'b00, 1'b0);
      op_chk("and", 4'd1, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 2'b00, 1'b0);
      op_chk("or", 4'd5, 16'h0F00, 16'h00F0, 16'h0FF0, 3'b001, 2'b00, 1'b0);
      op_chk("xor", 4'd6, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b100, 2'b00, 1'b0);
      op_chk("pass", 4'd3, 16'h1234, 16'hFFFF, 16'h1234, 3'b001, 2'b00, 1'b0);
      op_chk("add carry", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 2'b10, 1'b0);
      op_chk("sub borrow", 4'd4, 16'h0000, 16'h0001, 16'hFFFF, 3'b100, 2'b00, 1'b0);
      op_chk("sub ovf", 4'd4, 16'h8000, 16'h0001, 16'h7FFF, 3'b001, 2'b11, 1'b0);
      op_chk("sra", 4'd9, 16'h8000, 16'h0013, 16'hF000, 3'b100, 2'b00, 1'b0);
      op_chk("shr", 4'd8, 16'h8000, 16'h0013, 16'h1000, 3'b001, 2'b00, 1'b0);
      op_chk("shl", 4'd7, 16'h0001, 16'h0014, 16'h0010, 3'b001, 2'b00, 1'b0);
      op_chk("shl zero", 4'd7, 16'h1234, 16'h0010, 16'h1234, 3'b001, 2'b00, 1'b0);
      op_chk("illegal 14", 4'd14, 16'h1234, 16'h5678, 16'h0000, 3'b010, 2'b00, 1'b1);
      op_chk("illegal 11", 4'd11, 16'h0001, 16'h0001, 16'h0000, 3'b010, 2'b00, 1'b1);
      run_op(4'd10, 16'h0012, 16'h0034, lat);
      chk("mul lat", lat, 17);
      chk("mul q", q, 16'h03A8);
      chk("mul nzp", nzp, 3'b001);
      chk("mul cv", cv, 0);
      chk("mul err", err, 0);
      held = q;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("mul hold q", q, held);
         chk("mul hold in_ready", in_ready, 0);
         chk("mul hold valid", out_valid, 1);
      end
      ack();
      run_op(4'd10, 16'hFFFF, 16'hFFFF, lat);
      chk("mul wrap lat", lat, 17);
      chk("mul wrap q", q, 16'h0001);
      ack();
      out_ready = 1'b1;
      run_op(4'd0, 16'h0010, 16'h0020, lat);
      chk("fast ack lat", lat, 1);
      chk("fast ack q", q, 16'h0030);
      @(posedge clk); #1;
      chk("fast ack in_ready", in_ready, 1);
      chk("fast ack valid", out_valid, 0);
      out_ready = 1'b0;
      aluk = 4'd10; one = 16'h0003; two = 16'h0004; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      chk("nomul valid", out_valid0, 1);
      chk("nomul q", q0, 0);
      chk("nomul nzp", nzp0, 3'b010);
      chk("nomul err", err0, 1);
      chk("nomul cv", cv0, 0);
      chk("nomul main idle", out_valid, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      aluk = 4'd10; one = 16'h0012; two = 16'h0034; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid rst q", q, 0);
      chk("mid rst nzp", nzp, 0);
      chk("mid rst valid", out_valid, 0);
      chk("mid rst in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      chk("post rst no valid", lat, 0);
      op_chk("post rst add", 4'd0, 16'h0002, 16'h0003, 16'h0005, 3'b001, 2'b00, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width; legal range 4..64.
REQ-002 The block SHALL have parameter MUL_EN, default 1: 1 enables the iterative multiply op; 0 makes MUL an illegal op.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port aluk, input, 4 bits: operation select, sampled on accept.
REQ-006 The block SHALL have port one, input, WIDTH bits: operand A, sampled on accept.
REQ-007 The block SHALL have port two, input, WIDTH bits: operand B, sampled on accept.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the request is present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-010 The block SHALL have port q, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port nzp, output, 3 bits: {N,Z,P} of q; exactly one bit is set while out_valid=1.
REQ-012 The block SHALL have port cv, output, 2 bits: {carry, signed overflow}; meaningful for ADD/SUB, 0 for all other ops.
REQ-013 The block SHALL have port err, output, 1 bit: the accepted op was illegal.
REQ-014 The block SHALL have port out_valid, output, 1 bit: q/nzp/cv/err are valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-016 Op codes SHALL be: 0 ADD (A+B); 1 AND; 2 NOT (~A); 3 PASS (A); 4 SUB (A-B); 5 OR; 6 XOR; 7 SHL (A<<B[log2 WIDTH-1:0]); 8 SHR logical; 9 SRA arithmetic; 10 MUL (low WIDTH bits of A*B, unsigned).
REQ-017 Codes 11-15, and code 10 when MUL_EN=0, SHALL be illegal; an illegal op SHALL produce q=0, nzp=3'b010, cv=0, err=1.
REQ-018 A request SHALL be accepted on a rising clk edge with in_valid=1 and in_ready=1; aluk/one/two SHALL be captured on that edge and ignored thereafter.
REQ-019 The FSM SHALL have three states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 IDLE with accept of a non-MUL op: the result SHALL be registered on the accept edge and the FSM SHALL go to DONE, so out_valid=1 in the cycle after accept (latency 1).
REQ-021 IDLE with accept of a legal MUL: the FSM SHALL go to BUSY and run a shift-add multiply, one multiplier bit per cycle, with an internal counter from WIDTH-1 down to 0.
REQ-022 BUSY SHALL go to DONE on the cycle the counter reaches 0; total MUL latency from accept to out_valid SHALL be exactly WIDTH+1 cycles.
REQ-023 In DONE, out_valid SHALL be 1 and q/nzp/cv/err SHALL be held stable until a rising edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-024 An out_ready that is already high on entry to DONE SHALL complete the transfer in one cycle; no back-to-back accept SHALL occur in that cycle because in_ready=0.
REQ-025 ADD/SUB SHALL compute at WIDTH+1 bits; carry SHALL be bit WIDTH (for SUB, carry=1 means no borrow); overflow SHALL be set when the operand signs match (ADD) or differ (SUB) and the result sign differs from A.
REQ-026 NZP SHALL be computed from the registered q: N=q[WIDTH-1]; Z=(q==0); P otherwise.
REQ-027 Shift amounts SHALL use only the low log2(WIDTH) bits of B; upper bits SHALL be ignored; a shift of 0 SHALL return A.
REQ-028 out_ready SHALL be ignored in IDLE and BUSY; in_valid SHALL be ignored outside IDLE.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, q=0, nzp=3'b000, cv=0, err=0, out_valid=0, and in_ready=1 (after release).
REQ-030 A reset asserted mid-MUL or in DONE SHALL discard the operation; no out_valid SHALL follow the release.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 ADD with WIDTH=16, A=0x7FFF, B=0x0001: 1 cycle -> q=0x8000, nzp=100, cv=01, err=0.
REQ-033 SUB with A=0x0005, B=0x0005: q=0x0000, nzp=010, cv=10; then NOT of A=0x00FF -> q=0xFF00, nzp=100, cv=00.
REQ-034 MUL with A=0x0012, B=0x0034: out_valid exactly 17 cycles after accept, q=0x03A8, nzp=001; with out_ready held 0 for 5 further cycles, q stays stable and in_ready stays 0.
REQ-035 SRA with A=0x8000, B=0x0013 (effective shift 3): q=0xF000; SHR with the same operands: q=0x1000.
REQ-036 Illegal aluk=14: q=0, nzp=010, err=1; with MUL_EN=0, aluk=10 gives the same response.
REQ-037 rst_n pulsed low 5 cycles into a MUL: outputs go to reset values immediately, no out_valid follows, and a new ADD 2+3 accepted after release returns q=5.
